// File: rtl/wb_pkg.sv
// Shared types and sizing for the write-back buffer slice.
package wb_pkg;

  localparam int TAG_SZ = 11;
  localparam int IND_SZ = 9;
  localparam int BA_SZ  = TAG_SZ + IND_SZ;
  localparam int DEPTH  = 4;
  localparam int PTR_SZ = $clog2(DEPTH);

  typedef logic [BA_SZ-1:0] blk_addr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    FLUSH_ACK = 2'd2
  } wb_state_t;

  function automatic logic [DEPTH-1:0] ptr_onehot(input logic [PTR_SZ-1:0] ptr);
    logic [DEPTH-1:0] oh;
    oh      = {DEPTH{1'b0}};
    oh[ptr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo_store.sv
// Entry storage for the write-back buffer: circular FIFO with valid bits
// and a parallel compare of every entry against the lookup and eviction addresses.
module wb_fifo_store
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  blk_addr_t         wdata,
  input  blk_addr_t         lk_addr,
  input  blk_addr_t         cmp_addr,
  input  logic              head_busy,
  output blk_addr_t         head_addr,
  output logic              full,
  output logic [PTR_SZ:0]   occupancy,
  output logic              lk_hit,
  output logic [DEPTH-1:0]  merge_vec
);

  blk_addr_t          entry_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_SZ-1:0]  wr_ptr_r;
  logic [PTR_SZ-1:0]  rd_ptr_r;
  logic [PTR_SZ:0]    occ_r;
  logic [DEPTH-1:0]   lk_vec_s;
  logic [DEPTH-1:0]   push_oh_s;
  logic [DEPTH-1:0]   pop_oh_s;

  assign push_oh_s = push ? ptr_onehot(wr_ptr_r) : {DEPTH{1'b0}};
  assign pop_oh_s  = pop  ? ptr_onehot(rd_ptr_r) : {DEPTH{1'b0}};

  // Entry array, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {BA_SZ{1'b0}};
      end
      valid_r  <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_SZ{1'b0}};
      rd_ptr_r <= {PTR_SZ{1'b0}};
      occ_r    <= {(PTR_SZ+1){1'b0}};
    end else begin
      if (push) begin
        entry_r[wr_ptr_r] <= wdata;
        wr_ptr_r          <= wr_ptr_r + PTR_SZ'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_SZ'(1);
      end
      valid_r <= (valid_r & ~pop_oh_s) | push_oh_s;
      case ({push, pop})
        2'b10:   occ_r <= occ_r + (PTR_SZ+1)'(1);
        2'b01:   occ_r <= occ_r - (PTR_SZ+1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Parallel compare; the in-flight head is excluded only from the merge match
  always_comb begin
    lk_vec_s  = {DEPTH{1'b0}};
    merge_vec = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      lk_vec_s[i]  = valid_r[i] && (entry_r[i] == lk_addr);
      merge_vec[i] = valid_r[i] && (entry_r[i] == cmp_addr)
                     && !(head_busy && (rd_ptr_r == PTR_SZ'(i)));
    end
  end

  assign lk_hit    = |lk_vec_s;
  assign full      = (occ_r == (PTR_SZ+1)'(DEPTH));
  assign occupancy = occ_r;
  assign head_addr = entry_r[rd_ptr_r];

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer top: drain FSM, flush control and counters.
// Define WBUF_MERGE_EN to fold evictions matching a queued (not in-flight) entry.
module wb_buffer
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [BA_SZ-1:0]  wb_addr,
  output logic              wb_ready,
  output logic              mem_valid,
  output logic [BA_SZ-1:0]  mem_addr,
  input  logic              mem_ready,
  input  logic [BA_SZ-1:0]  lk_addr,
  output logic              lk_hit,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [PTR_SZ:0]   occupancy,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       drain_cnt
);

`ifdef WBUF_MERGE_EN
  localparam logic MERGE_EN = 1'b1;
`else
  localparam logic MERGE_EN = 1'b0;
`endif

  wb_state_t         state_r;
  wb_state_t         state_nx_s;
  blk_addr_t         mem_addr_r;
  blk_addr_t         head_addr_s;
  logic              flush_active_r;
  logic [31:0]       wr_cnt_r;
  logic [31:0]       drain_cnt_r;
  logic              full_s;
  logic [PTR_SZ:0]   occ_s;
  logic [DEPTH-1:0]  merge_vec_s;
  logic              send_s;
  logic              push_s;
  logic              alloc_s;
  logic              pop_s;

  assign send_s   = (state_r == SEND);
  assign wb_ready = !full_s && !flush_active_r;
  assign push_s   = wb_valid && wb_ready;
  assign alloc_s  = push_s && !(MERGE_EN && (|merge_vec_s));
  assign pop_s    = send_s && mem_ready;

  wb_fifo_store u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alloc_s),
    .pop       (pop_s),
    .wdata     (wb_addr),
    .lk_addr   (lk_addr),
    .cmp_addr  (wb_addr),
    .head_busy (send_s),
    .head_addr (head_addr_s),
    .full      (full_s),
    .occupancy (occ_s),
    .lk_hit    (lk_hit),
    .merge_vec (merge_vec_s)
  );

  // Drain FSM next state; draining has priority over acknowledging a flush
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (occ_s != {(PTR_SZ+1){1'b0}}) begin
          state_nx_s = SEND;
        end else if (flush_active_r) begin
          state_nx_s = FLUSH_ACK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SEND: begin
        if (mem_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = SEND;
        end
      end
      FLUSH_ACK: state_nx_s = IDLE;
      default:   state_nx_s = IDLE;
    endcase
  end

  // State, latched memory address, flush flag and event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      mem_addr_r     <= {BA_SZ{1'b0}};
      flush_active_r <= 1'b0;
      wr_cnt_r       <= 32'd0;
      drain_cnt_r    <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      if ((state_r == IDLE) && (state_nx_s == SEND)) begin
        mem_addr_r <= head_addr_s;
      end
      if (state_r == FLUSH_ACK) begin
        flush_active_r <= 1'b0;
      end else if (flush_req) begin
        flush_active_r <= 1'b1;
      end
      if (push_s) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
      if (pop_s) begin
        drain_cnt_r <= drain_cnt_r + 32'd1;
      end
    end
  end

  assign mem_valid  = send_s;
  assign mem_addr   = mem_addr_r;
  assign flush_done = (state_r == FLUSH_ACK);
  assign occupancy  = occ_s;
  assign wr_cnt     = wr_cnt_r;
  assign drain_cnt  = drain_cnt_r;

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: vector table, scripted corner cases and
// a randomized run against a queue-based reference model.
module tb_wb_buffer;

  localparam int DEPTH = 4;
`ifdef WBUF_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [19:0] wb_addr;
  logic        wb_ready;
  logic        mem_valid;
  logic [19:0] mem_addr;
  logic        mem_ready;
  logic [19:0] lk_addr;
  logic        lk_hit;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  occupancy;
  logic [31:0] wr_cnt;
  logic [31:0] drain_cnt;

  wb_buffer dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_ready(wb_ready), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .lk_addr(lk_addr), .lk_hit(lk_hit),
    .flush_req(flush_req), .flush_done(flush_done), .occupancy(occupancy),
    .wr_cnt(wr_cnt), .drain_cnt(drain_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending addresses in arrival order plus handshake phases
  logic [19:0] q[$];
  bit          m_busy;
  bit          m_ack;
  bit          m_pend;
  int unsigned m_wr;
  int unsigned m_dr;

  typedef struct {
    logic        wv;
    logic [19:0] wa;
    logic        mr;
    logic [19:0] lk;
    logic [2:0]  occ;
    logic        mv;
    logic [19:0] ma;
    logic        rdy;
    logic        hit;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit rdy, acc, merged, nb, na, np;
    int start;
    if (!rst_n) begin
      q.delete();
      m_busy = 1'b0; m_ack = 1'b0; m_pend = 1'b0; m_wr = 0; m_dr = 0;
    end else begin
      rdy    = (q.size() < DEPTH) && !m_pend;
      acc    = wb_valid && rdy;
      merged = 1'b0;
      start  = m_busy ? 1 : 0;
      if (acc && MERGE) begin
        for (int i = start; i < q.size(); i++) begin
          if (q[i] == wb_addr) merged = 1'b1;
        end
      end
      nb = m_busy ? !mem_ready : (!m_ack && (q.size() > 0));
      na = !m_busy && !m_ack && (q.size() == 0) && m_pend;
      np = m_ack ? 1'b0 : (m_pend || flush_req);
      if (m_busy && mem_ready) begin
        void'(q.pop_front());
        m_dr++;
      end
      if (acc) begin
        m_wr++;
        if (!merged) q.push_back(wb_addr);
      end
      m_busy = nb; m_ack = na; m_pend = np;
    end
  endtask

  task automatic check_model();
    bit hit;
    hit = 1'b0;
    foreach (q[i]) if (q[i] == lk_addr) hit = 1'b1;
    chk("m_occupancy", 32'(occupancy), 32'(q.size()));
    chk("m_mem_valid", 32'(mem_valid), 32'(m_busy));
    if (m_busy) chk("m_mem_addr", 32'(mem_addr), 32'(q[0]));
    chk("m_wb_ready", 32'(wb_ready), 32'((q.size() < DEPTH) && !m_pend));
    chk("m_flush_done", 32'(flush_done), 32'(m_ack));
    chk("m_wr_cnt", wr_cnt, m_wr);
    chk("m_drain_cnt", drain_cnt, m_dr);
    chk("m_lk_hit", 32'(lk_hit), 32'(hit));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = 20'h0; mem_ready = 1'b0;
    flush_req = 1'b0; lk_addr = 20'h0;
    cycle();
    cycle();
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);
    chk("rst_drain_cnt", drain_cnt, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [19:0] a);
    wb_valid = 1'b1; wb_addr = a;
    cycle();
    wb_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int pulses;

    // Fill to full with memory stalled, then drain in order
    tbl[0]  = '{1'b1, 20'h1, 1'b0, 20'h1, 3'd1, 1'b0, 20'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 20'h2, 1'b0, 20'h2, 3'd2, 1'b1, 20'h1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 20'h3, 1'b0, 20'h9, 3'd3, 1'b1, 20'h1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 20'h4, 1'b0, 20'h4, 3'd4, 1'b1, 20'h1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 20'h5, 1'b0, 20'h5, 3'd4, 1'b1, 20'h1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 20'h0, 1'b1, 20'h1, 3'd3, 1'b0, 20'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 20'h0, 1'b1, 20'h2, 3'd3, 1'b1, 20'h2, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 20'h0, 1'b1, 20'h2, 3'd2, 1'b0, 20'h0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 20'h0, 1'b1, 20'h3, 3'd2, 1'b1, 20'h3, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 20'h0, 1'b1, 20'h4, 3'd1, 1'b0, 20'h0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 20'h0, 1'b1, 20'h4, 3'd1, 1'b1, 20'h4, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 20'h0, 1'b1, 20'h4, 3'd0, 1'b0, 20'h0, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      wb_valid = tbl[i].wv; wb_addr = tbl[i].wa; mem_ready = tbl[i].mr; lk_addr = tbl[i].lk;
      cycle();
      chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
      chk($sformatf("tbl%0d_mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
      if (tbl[i].mv) chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
      chk($sformatf("tbl%0d_wb_ready", i), 32'(wb_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_lk_hit", i), 32'(lk_hit), 32'(tbl[i].hit));
    end
    wb_valid = 1'b0;
    chk("fill_drain_cnt", drain_cnt, 32'd4);
    chk("fill_wr_cnt", wr_cnt, 32'd4);

    // Single eviction latency
    do_reset();
    mem_ready = 1'b1;
    push_one(20'h12345);
    chk("single_occ_after_push", 32'(occupancy), 32'd1);
    chk("single_mv_after_push", 32'(mem_valid), 32'd0);
    cycle();
    chk("single_mem_valid", 32'(mem_valid), 32'd1);
    chk("single_mem_addr", 32'(mem_addr), 32'h12345);
    cycle();
    chk("single_drain_cnt", drain_cnt, 32'd1);
    chk("single_occ_done", 32'(occupancy), 32'd0);

    // Lookup against queued and in-flight entries, then reset mid-transfer
    do_reset();
    push_one(20'hABCDE);
    push_one(20'h00010);
    lk_addr = 20'hABCDE; #1;
    chk("lookup_hit", 32'(lk_hit), 32'd1);
    lk_addr = 20'hABCDF; #1;
    chk("lookup_miss", 32'(lk_hit), 32'd0);
    chk("lookup_inflight", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    rst_n = 1'b1;

    // Flush with a push attempted throughout
    do_reset();
    mem_ready = 1'b1;
    push_one(20'h100);
    push_one(20'h101);
    push_one(20'h102);
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    wb_valid = 1'b1; wb_addr = 20'h777;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      chk("flush_wb_ready", 32'(wb_ready), 32'd0);
      if (flush_done) begin
        seen = 1'b1;
        chk("flush_occ", 32'(occupancy), 32'd0);
      end
    end
    if (!seen) chk("flush_timeout", 32'd0, 32'd1);
    wb_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (flush_done) pulses++;
    end
    chk("flush_single_pulse", 32'(pulses), 32'd0);
    chk("flush_wb_ready_after", 32'(wb_ready), 32'd1);
    chk("flush_wr_cnt", wr_cnt, 32'd3);
    chk("flush_drain_cnt", drain_cnt, 32'd3);

    // Duplicate eviction while another entry is in flight
    do_reset();
    push_one(20'h5);
    push_one(20'h6);
    push_one(20'h6);
    cycle();
    chk("merge_occ", 32'(occupancy), MERGE ? 32'd2 : 32'd3);
    chk("merge_wr_cnt", wr_cnt, 32'd3);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      wb_valid  = ($urandom_range(0, 9) < 6);
      wb_addr   = 20'($urandom_range(0, 5));
      mem_ready = 1'($urandom_range(0, 1));
      flush_req = ($urandom_range(0, 19) == 0);
      lk_addr   = 20'($urandom_range(0, 6));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
